// File: rtl/vga_scanout.sv
// vga_scanout: VGA 640x480@60 timing generator and pixel-FIFO consumer.
// It pops one RGB565 word per visible pixel slot and fires the per-frame
// renderer trigger. During vertical blank it drains whatever the renderer
// left behind, so a short or long frame never shifts the next frame's pixels.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_rd,
  output logic        trigger,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [4:0]  red,
  output logic [5:0]  green,
  output logic [4:0]  blue,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  // Trigger line: two lines before line 0 gives the renderer a head start.
  localparam logic [VW-1:0] V_TRIG = VW'(V_TOTAL - 2);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          run;

  logic visible;
  logic flush;
  logic pop;
  logic hs_zone;
  logic vs_zone;

  assign visible = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hs_zone = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_zone = (vcnt >= VS_BEG) && (vcnt < VS_END);

  // Drain window covers the blank lines up to (not including) the trigger
  // line, so nothing is discarded once the renderer starts the next frame.
  assign flush   = run && (vcnt >= V_VIS) && (vcnt < V_TRIG);
  assign pop     = run && pix_en && visible && !fifo_empty;

  // Both terms depend on run, which clears asynchronously, so the pop
  // request drops the instant reset asserts.
  assign fifo_rd = pop || (flush && !fifo_empty);
  assign trigger = run && pix_en && (hcnt == '0) && (vcnt == V_TRIG);

  // run marks the first clk after reset release; gates all FIFO activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Raster counters; start in vblank so the first trigger precedes line 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= V_VIS;
    end else if (pix_en) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Video output register: syncs, de and pixel share one pix_en of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pix_en) begin
      hsync <= !hs_zone;
      vsync <= !vs_zone;
      de    <= visible;
      if (pop) begin
        red   <= fifo_data[15:11];
        green <= fifo_data[10:5];
        blue  <= fifo_data[4:0];
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

  // Sticky underflow flag; a new starved pixel beats a same-clk clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   underflow <= 1'b0;
    else if (run && pix_en && visible && fifo_empty) underflow <= 1'b1;
    else if (underflow_clr)                       underflow <= 1'b0;
  end

endmodule
